// File: rtl/pacote_registrador.sv
// Shared definitions for the universal shift register: mode encodings and default width.
package pacote_registrador;

    localparam int unsigned NBITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        LOAD = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        ROL  = 3'd4,
        ROR  = 3'd5,
        CLR  = 3'd6
    } modo_t;

endpackage

// File: rtl/contador_quadro.sv
// Frame counter: counts shifts and pulses frame_done on the edge committing the NBITS-th shift.
module contador_quadro #(
    parameter int unsigned NBITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inc,
    input  logic                     clr,
    output logic [$clog2(NBITS)-1:0] cnt,
    output logic                     frame_done
);

    localparam int unsigned        CW      = $clog2(NBITS);
    localparam logic [CW-1:0]      CNT_MAX = CW'(NBITS - 1);

    // clr (load/clear) outranks inc; they are mutually exclusive from the top anyway
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            frame_done <= 1'b0;
        end else if (clr) begin
            cnt        <= '0;
            frame_done <= 1'b0;
        end else if (inc) begin
            if (cnt == CNT_MAX) begin
                cnt        <= '0;
                frame_done <= 1'b1;
            end else begin
                cnt        <= cnt + CW'(1);
                frame_done <= 1'b0;
            end
        end else begin
            frame_done <= 1'b0;
        end
    end

endmodule

// File: rtl/registrador_universal_serial.sv
// Parametrised universal shift register with serial taps at both ends and a frame counter.
module registrador_universal_serial
    import pacote_registrador::*;
#(
    parameter int unsigned NBITS = NBITS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [2:0]               modo,
    input  logic [NBITS-1:0]         Din,
    input  logic                     sin_lsb,
    input  logic                     sin_msb,
    output logic [NBITS-1:0]         Dout,
    output logic                     sout_msb,
    output logic                     sout_lsb,
    output logic                     frame_done,
    output logic [$clog2(NBITS)-1:0] cnt
);

    modo_t            modo_sel;
    logic [NBITS-1:0] dout_next;
    logic             is_shift;
    logic             is_restart;
    logic             inc;
    logic             clr;

    // Mode mux; reserved code 7 falls into default and holds
    always_comb begin
        modo_sel   = modo_t'(modo);
        dout_next  = Dout;
        is_shift   = 1'b0;
        is_restart = 1'b0;
        case (modo_sel)
            LOAD: begin
                dout_next  = Din;
                is_restart = 1'b1;
            end
            SHL: begin
                dout_next = {Dout[NBITS-2:0], sin_lsb};
                is_shift  = 1'b1;
            end
            SHR: begin
                dout_next = {sin_msb, Dout[NBITS-1:1]};
                is_shift  = 1'b1;
            end
            ROL: begin
                dout_next = {Dout[NBITS-2:0], Dout[NBITS-1]};
                is_shift  = 1'b1;
            end
            ROR: begin
                dout_next = {Dout[0], Dout[NBITS-1:1]};
                is_shift  = 1'b1;
            end
            CLR: begin
                dout_next  = '0;
                is_restart = 1'b1;
            end
            default: dout_next = Dout;
        endcase
        inc = en & is_shift;
        clr = en & is_restart;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Dout <= '0;
        end else if (en) begin
            Dout <= dout_next;
        end
    end

    assign sout_msb = Dout[NBITS-1];
    assign sout_lsb = Dout[0];

    contador_quadro #(
        .NBITS (NBITS)
    ) u_contador_quadro (
        .clk        (clk),
        .reset      (reset),
        .inc        (inc),
        .clr        (clr),
        .cnt        (cnt),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_registrador_universal_serial.sv
// Self-checking bench: behavioural model compared every cycle plus directed literal checks.
module tb_registrador_universal_serial;
    import pacote_registrador::*;

    localparam int unsigned N  = 8;
    localparam int unsigned CW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [2:0]    modo;
    logic [N-1:0]  Din;
    logic          sin_lsb;
    logic          sin_msb;
    logic [N-1:0]  Dout;
    logic          sout_msb;
    logic          sout_lsb;
    logic          frame_done;
    logic [CW-1:0] cnt;

    int n_checks = 0;
    int n_fail   = 0;

    registrador_universal_serial #(.NBITS(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .modo       (modo),
        .Din        (Din),
        .sin_lsb    (sin_lsb),
        .sin_msb    (sin_msb),
        .Dout       (Dout),
        .sout_msb   (sout_msb),
        .sout_lsb   (sout_lsb),
        .frame_done (frame_done),
        .cnt        (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: integer arithmetic, shift count kept modulo N
    int unsigned m_d     = 0;
    int unsigned m_c     = 0;
    int unsigned m_fd    = 0;
    bit          m_valid = 0;
    localparam int unsigned MASK = (1 << N) - 1;

    always @(posedge clk) begin
        if (reset) begin
            m_d = 0; m_c = 0; m_fd = 0; m_valid = 1;
        end else if (!en) begin
            m_fd = 0;
        end else begin
            m_fd = 0;
            case (int'(modo))
                1: begin m_d = int'(Din); m_c = 0; end
                2, 3, 4, 5: begin
                    case (int'(modo))
                        2: m_d = ((m_d * 2) + int'(sin_lsb)) & MASK;
                        3: m_d = (m_d / 2) + (int'(sin_msb) << (N - 1));
                        4: m_d = ((m_d * 2) & MASK) + (m_d >> (N - 1));
                        default: m_d = (m_d / 2) + ((m_d % 2) << (N - 1));
                    endcase
                    m_c = (m_c + 1) % N;
                    if (m_c == 0) m_fd = 1;
                end
                6: begin m_d = 0; m_c = 0; end
                default: ;
            endcase
        end
    end

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("dout_model", 32'(Dout), 32'(m_d));
            check("cnt_model", 32'(cnt), 32'(m_c));
            check("frame_done_model", 32'(frame_done), 32'(m_fd));
            check("sout_msb_model", 32'(sout_msb), 32'((m_d >> (N - 1)) & 1));
            check("sout_lsb_model", 32'(sout_lsb), 32'(m_d & 1));
        end
    end

    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [N-1:0] d, input logic sl, input logic sm);
        @(negedge clk);
        reset = r; en = e; modo = m; Din = d; sin_lsb = sl; sin_msb = sm;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] pat;
        int fd_count;
        reset = 1'b1; en = 1'b0; modo = 3'd0; Din = '0; sin_lsb = 1'b0; sin_msb = 1'b0;

        // Reset beats a simultaneous LOAD
        step(1'b1, 1'b1, LOAD, 8'hFF, 1'b0, 1'b0);
        check("reset_dout", 32'(Dout), 32'h00);
        check("reset_cnt", 32'(cnt), 32'd0);
        check("reset_fd", 32'(frame_done), 32'd0);
        check("reset_sout", 32'({sout_msb, sout_lsb}), 32'd0);

        // Serialize 0xA5 MSB first while filling with ones
        step(1'b0, 1'b1, LOAD, 8'hA5, 1'b0, 1'b0);
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            check("ser_sout_msb", 32'(sout_msb), 32'(pat[7 - i]));
            step(1'b0, 1'b1, SHL, 8'h00, 1'b1, 1'b0);
            check("ser_fd", 32'(frame_done), (i == 7) ? 32'd1 : 32'd0);
        end
        check("ser_dout", 32'(Dout), 32'hFF);
        check("ser_cnt", 32'(cnt), 32'd0);
        step(1'b0, 1'b1, HOLD, 8'h00, 1'b0, 1'b0);
        check("ser_fd_drop", 32'(frame_done), 32'd0);

        // Rotates
        step(1'b0, 1'b1, LOAD, 8'h81, 1'b0, 1'b0);
        step(1'b0, 1'b1, ROL, 8'h00, 1'b0, 1'b0);
        check("rol_dout", 32'(Dout), 32'h03);
        step(1'b0, 1'b1, ROR, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, ROR, 8'h00, 1'b0, 1'b0);
        check("ror2_dout", 32'(Dout), 32'hC0);
        step(1'b0, 1'b1, ROR, 8'h00, 1'b0, 1'b0);
        check("ror3_dout", 32'(Dout), 32'h60);
        check("rot_cnt", 32'(cnt), 32'd4);
        check("rot_fd", 32'(frame_done), 32'd0);

        // Deserialize through the MSB end
        step(1'b0, 1'b1, CLR, 8'h00, 1'b0, 1'b0);
        check("clr_cnt", 32'(cnt), 32'd0);
        pat = 8'b1100_1010;
        fd_count = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, SHR, 8'h00, 1'b0, pat[7 - i]);
            fd_count += int'(frame_done);
        end
        check("deser_dout", 32'(Dout), 32'h53);
        check("deser_fd_count", 32'(fd_count), 32'd1);
        check("deser_cnt", 32'(cnt), 32'd0);

        // Freeze with en=0 and reserved mode mid-frame
        step(1'b0, 1'b1, LOAD, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, SHL, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, LOAD, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 3'd7, 8'hFF, 1'b1, 1'b1);
        check("freeze_dout", 32'(Dout), 32'hE0);
        check("freeze_cnt", 32'(cnt), 32'd3);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, SHL, 8'h00, 1'b1, 1'b0);
            check("freeze_fd", 32'(frame_done), (i == 4) ? 32'd1 : 32'd0);
        end
        // en=0 right after a frame boundary forces frame_done low
        step(1'b0, 1'b0, SHL, 8'h00, 1'b1, 1'b0);
        check("en0_fd", 32'(frame_done), 32'd0);

        // Reset mid-frame restarts the count
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, SHL, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, SHL, 8'h00, 1'b1, 1'b0);
        check("midrst_dout", 32'(Dout), 32'h00);
        check("midrst_cnt", 32'(cnt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, SHL, 8'h00, 1'b1, 1'b0);
            check("midrst_fd", 32'(frame_done), (i == 7) ? 32'd1 : 32'd0);
        end
        check("midrst_dout_final", 32'(Dout), 32'hFF);

        step(1'b0, 1'b1, HOLD, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
